// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the block-wide Dmem port between I-cache refill and D-cache refill/writeback.
// Optional ARB_ROUND_ROBIN_EN selects round-robin instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned BLOCK_W = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_ren,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_ready,
  output logic               i_done,
  output logic [BLOCK_W-1:0] i_dout,
  input  logic               d_ren,
  input  logic               d_wen,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_din,
  output logic               d_ready,
  output logic               d_done,
  output logic [BLOCK_W-1:0] d_dout,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [ADDR_W-1:0]  mem_block_address,
  output logic [BLOCK_W-1:0] mem_din,
  input  logic               mem_ready,
  input  logic               mem_done,
  input  logic [BLOCK_W-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t               state;
  logic                 gnt_i;
  logic                 gnt_d;
  logic                 lat_wr;
  logic [ADDR_W-1:0]    lat_addr;
  logic [BLOCK_W-1:0]   lat_din;

  logic pend_i;
  logic pend_d;
  logic pick_d;

  assign pend_i = i_ren;
  assign pend_d = d_ren | d_wen;

`ifdef ARB_ROUND_ROBIN_EN
  // High when D holds priority for the next contended grant.
  logic rr_d_pri;

  always_comb begin
    pick_d = pend_d & (~pend_i | rr_d_pri);
  end
`else
  always_comb begin
    pick_d = pend_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      gnt_i             <= 1'b0;
      gnt_d             <= 1'b0;
      lat_wr            <= 1'b0;
      lat_addr          <= '0;
      lat_din           <= '0;
      i_ready           <= 1'b0;
      d_ready           <= 1'b0;
      i_done            <= 1'b0;
      d_done            <= 1'b0;
      i_dout            <= '0;
      d_dout            <= '0;
      mem_ren           <= 1'b0;
      mem_wen           <= 1'b0;
      mem_block_address <= '0;
      mem_din           <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_d_pri          <= 1'b1;
`endif
    end else begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pend_i | pend_d) begin
            // Latch the winner so later input changes cannot disturb the transaction.
            gnt_d    <= pick_d;
            gnt_i    <= ~pick_d;
            lat_wr   <= pick_d & d_wen;
            lat_addr <= pick_d ? d_addr : i_addr;
            lat_din  <= pick_d ? d_din : '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_d_pri <= ~pick_d;
`endif
            state    <= S_ISSUE;
          end else begin
            i_ready <= 1'b1;
            d_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            mem_ren           <= ~lat_wr;
            mem_wen           <= lat_wr;
            mem_block_address <= lat_addr;
            mem_din           <= lat_din;
            state             <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            if (gnt_d) begin
              d_done <= 1'b1;
              if (!lat_wr) begin
                d_dout <= mem_dout;
              end
            end else begin
              i_done <= 1'b1;
              i_dout <= mem_dout;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          gnt_i   <= 1'b0;
          gnt_d   <= 1'b0;
          i_ready <= 1'b1;
          d_ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of full transactions plus reset/stall corner sequences.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned BLOCK_W = 256;

  logic               clock;
  logic               reset;
  logic               i_ren;
  logic [ADDR_W-1:0]  i_addr;
  logic               i_ready;
  logic               i_done;
  logic [BLOCK_W-1:0] i_dout;
  logic               d_ren;
  logic               d_wen;
  logic [ADDR_W-1:0]  d_addr;
  logic [BLOCK_W-1:0] d_din;
  logic               d_ready;
  logic               d_done;
  logic [BLOCK_W-1:0] d_dout;
  logic               mem_ren;
  logic               mem_wen;
  logic [ADDR_W-1:0]  mem_block_address;
  logic [BLOCK_W-1:0] mem_din;
  logic               mem_ready;
  logic               mem_done;
  logic [BLOCK_W-1:0] mem_dout;

  int n_checks = 0;
  int n_errors = 0;

  logic [BLOCK_W-1:0] exp_i_dout;
  logic [BLOCK_W-1:0] exp_d_dout;

  mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
    .clock(clock), .reset(reset),
    .i_ren(i_ren), .i_addr(i_addr), .i_ready(i_ready), .i_done(i_done), .i_dout(i_dout),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_din(d_din),
    .d_ready(d_ready), .d_done(d_done), .d_dout(d_dout),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_block_address(mem_block_address),
    .mem_din(mem_din), .mem_ready(mem_ready), .mem_done(mem_done), .mem_dout(mem_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic               i_ren;
    logic [ADDR_W-1:0]  i_addr;
    logic               d_ren;
    logic               d_wen;
    logic [ADDR_W-1:0]  d_addr;
    logic [BLOCK_W-1:0] d_din;
    logic [BLOCK_W-1:0] rdata;
    logic               exp_d;
    logic               exp_wr;
    logic [ADDR_W-1:0]  exp_addr;
    logic [BLOCK_W-1:0] exp_din;
  } vec_t;

  vec_t vecs[9];

  // One complete transaction from IDLE back to IDLE with mem_ready held high.
  task automatic run_txn(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_pre_ready"}, {254'd0, i_ready, d_ready}, 256'd3);
    i_ren = v.i_ren; i_addr = v.i_addr;
    d_ren = v.d_ren; d_wen = v.d_wen; d_addr = v.d_addr; d_din = v.d_din;
    mem_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_busy_ready"}, {254'd0, i_ready, d_ready}, 256'd0);
    chk({tag, "_no_strobe_issue"}, {254'd0, mem_ren, mem_wen}, 256'd0);
    i_addr = ~v.i_addr; d_addr = ~v.d_addr; d_din = ~v.d_din;
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_strobe"}, {254'd0, mem_ren, mem_wen}, {254'd0, ~v.exp_wr, v.exp_wr});
    chk({tag, "_addr"}, 256'(mem_block_address), 256'(v.exp_addr));
    if (v.exp_wr) chk({tag, "_din"}, mem_din, v.exp_din);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_strobe_hold"}, {254'd0, mem_ren, mem_wen}, {254'd0, ~v.exp_wr, v.exp_wr});
    chk({tag, "_addr_hold"}, 256'(mem_block_address), 256'(v.exp_addr));
    chk({tag, "_no_early_done"}, {254'd0, i_done, d_done}, 256'd0);
    mem_done = 1'b1; mem_dout = v.rdata;
    @(posedge clock);
    @(negedge clock);
    mem_done = 1'b0; mem_dout = '0;
    if (v.exp_d && !v.exp_wr) exp_d_dout = v.rdata;
    if (!v.exp_d) exp_i_dout = v.rdata;
    chk({tag, "_done"}, {254'd0, i_done, d_done}, {254'd0, ~v.exp_d, v.exp_d});
    chk({tag, "_strobe_low"}, {254'd0, mem_ren, mem_wen}, 256'd0);
    chk({tag, "_i_dout"}, i_dout, exp_i_dout);
    if (!v.exp_wr) chk({tag, "_d_dout"}, d_dout, exp_d_dout);
    i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_done_pulse_end"}, {254'd0, i_done, d_done}, 256'd0);
    chk({tag, "_release_ready"}, {254'd0, i_ready, d_ready}, 256'd0);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_idle_ready"}, {254'd0, i_ready, d_ready}, 256'd3);
    chk({tag, "_idle_strobe"}, {254'd0, mem_ren, mem_wen}, 256'd0);
  endtask

  initial begin
    logic rr;
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    //          i_ren i_addr d_ren d_wen d_addr d_din              rdata             exp_d  exp_wr exp_addr exp_din
    vecs[0] = '{1'b0, 5'h00, 1'b0, 1'b1, 5'h03, 256'hA5,           256'h77,          1'b1, 1'b1, 5'h03, 256'hA5};
    vecs[1] = '{1'b1, 5'h03, 1'b0, 1'b0, 5'h00, 256'h0,            256'hA5,          1'b0, 1'b0, 5'h03, 256'h0};
    vecs[2] = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h1F, 256'h0,            {4{64'hDEADBEEF_01234567}}, 1'b1, 1'b0, 5'h1F, 256'h0};
    vecs[3] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h0A, {8{32'hC0FFEE11}}, 256'h5,           1'b1, 1'b1, 5'h0A, {8{32'hC0FFEE11}}};
    vecs[4] = '{1'b1, 5'h10, 1'b0, 1'b0, 5'h00, 256'h0,            256'h1234,        1'b0, 1'b0, 5'h10, 256'h0};
    // Contended rounds: fixed priority always D; round-robin alternates starting with D.
    vecs[5] = '{1'b1, 5'h01, 1'b1, 1'b0, 5'h02, 256'h0, 256'h51, 1'b1, 1'b0, 5'h02, 256'h0};
    vecs[6] = '{1'b1, 5'h01, 1'b1, 1'b0, 5'h02, 256'h0, 256'h62, ~rr, 1'b0, rr ? 5'h01 : 5'h02, 256'h0};
    vecs[7] = '{1'b1, 5'h01, 1'b1, 1'b0, 5'h02, 256'h0, 256'h73, 1'b1, 1'b0, 5'h02, 256'h0};
    vecs[8] = '{1'b1, 5'h01, 1'b1, 1'b0, 5'h02, 256'h0, 256'h84, ~rr, 1'b0, rr ? 5'h01 : 5'h02, 256'h0};

    reset = 1'b1;
    i_ren = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0; d_addr = '0; d_din = '0;
    mem_ready = 1'b1; mem_done = 1'b0; mem_dout = '0;
    exp_i_dout = '0; exp_d_dout = '0;

    // Reset: two cycles, everything low.
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {254'd0, i_ready, d_ready}, 256'd0);
    chk("rst_done", {254'd0, i_done, d_done}, 256'd0);
    chk("rst_strobe", {254'd0, mem_ren, mem_wen}, 256'd0);
    chk("rst_addr", 256'(mem_block_address), 256'd0);
    chk("rst_din", mem_din, 256'd0);
    chk("rst_i_dout", i_dout, 256'd0);
    chk("rst_d_dout", d_dout, 256'd0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_ready", {254'd0, i_ready, d_ready}, 256'd3);

    for (int k = 0; k < 9; k++) run_txn(vecs[k], k);

    // Reset while waiting for Dmem aborts the I read silently.
    i_ren = 1'b1; i_addr = 5'h07; mem_ready = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("abort_strobe_up", {254'd0, mem_ren, mem_wen}, 256'd2);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_strobe_low", {254'd0, mem_ren, mem_wen}, 256'd0);
    chk("abort_no_done", {254'd0, i_done, d_done}, 256'd0);
    chk("abort_i_dout", i_dout, 256'd0);
    exp_i_dout = '0; exp_d_dout = '0;
    reset = 1'b0; i_ren = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("abort_idle_ready", {254'd0, i_ready, d_ready}, 256'd3);
    chk("abort_idle_strobe", {254'd0, mem_ren, mem_wen}, 256'd0);
    mem_done = 1'b1; mem_dout = 256'hBAD;
    @(posedge clock);
    @(negedge clock);
    chk("stray_done_ignored", {254'd0, i_done, d_done}, 256'd0);
    chk("stray_done_ready", {254'd0, i_ready, d_ready}, 256'd3);
    mem_done = 1'b0; mem_dout = '0;

    // Read+write together is a write; strobe waits for mem_ready, stray mem_done in ISSUE ignored.
    mem_ready = 1'b0;
    d_ren = 1'b1; d_wen = 1'b1; d_addr = 5'h15; d_din = {16{16'h9C3A}};
    @(posedge clock);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("stall_c%0d_strobe", c), {254'd0, mem_ren, mem_wen}, 256'd0);
      chk($sformatf("stall_c%0d_done", c), {254'd0, i_done, d_done}, 256'd0);
      mem_done = (c == 1);
      @(posedge clock);
    end
    @(negedge clock);
    chk("stall_end_strobe", {254'd0, mem_ren, mem_wen}, 256'd0);
    mem_done = 1'b0; mem_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("stall_wen", {254'd0, mem_ren, mem_wen}, 256'd1);
    chk("stall_addr", 256'(mem_block_address), 256'h15);
    chk("stall_din", mem_din, {16{16'h9C3A}});
    mem_done = 1'b1; mem_dout = 256'h3;
    @(posedge clock);
    @(negedge clock);
    chk("stall_d_done", {254'd0, i_done, d_done}, 256'd1);
    chk("stall_strobe_low", {254'd0, mem_ren, mem_wen}, 256'd0);
    mem_done = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("stall_final_ready", {254'd0, i_ready, d_ready}, 256'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
